nibble_bus_ram_port: RTL and testbench
======================================

Name: nibble_bus_ram_port

Overview:
- Upstream controller for port A of the 16K x 8 dual-port block RAM.
- Accepts the Arduino's 4-bit strobe/ack parallel bus, decodes a small command protocol (set address, write byte, read byte), and drives the RAM port-A signals.
- Address auto-increments after every data access, so the Arduino can stream bytes into or out of the RAM.
- Port B stays free for the FPGA-side consumer.

Parameters:
- ADDR_W, 14, RAM address width; the pointer wraps modulo 2^ADDR_W.
- SYNC_STAGES, 2, flip-flop stages synchronising io_strobe and io_sel_n.
- RD_LATENCY, 1, sys_clk cycles from RAM read issue to valid ram_douta. Use 1 for bypass read mode, 2 for pipeline.

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- io_sel_n  in  1  Arduino frame select (async); low = frame active.
- io_strobe  in  1  Arduino nibble strobe (async); four-phase with io_ack.
- io_din  in  4  nibble from the Arduino; stable while io_strobe is high.
- io_dout  out  4  nibble to the Arduino; valid while io_ack is high in read phase.
- io_dout_oe  out  1  high while the block drives io_dout (read data phase).
- io_ack  out  1  handshake acknowledge.
- ram_ada  out  ADDR_W  RAM port-A address.
- ram_dina  out  8  RAM port-A write data.
- ram_douta  in  8  RAM port-A read data.
- ram_cea  out  1  RAM port-A clock enable; single-cycle pulse per access.
- ram_wrea  out  1  RAM port-A write enable; qualifies ram_cea.
- ram_ocea  out  1  tied high.
- ram_reseta  out  1  tied low.
- busy  out  1  high whenever state is not IDLE.
- err  out  1  sticky high on unknown opcode; cleared by reset or by a SET_ADDR command.

Behaviour:
- Synchronisation and handshake:
  - io_strobe and io_sel_n pass through SYNC_STAGES flip-flops. The edge detector produces one-cycle stb_rise and stb_fall pulses.
  - Four-phase protocol: on stb_rise the block consumes or produces a nibble and raises io_ack within 3 cycles of the sync output. io_ack stays high until stb_fall, then drops the next cycle.
  - A new stb_rise while io_ack is still high is impossible by protocol and is ignored.
- Frame framing:
  - The first nibble after io_sel_n falls is the opcode.
  - io_sel_n high (synchronised) in any state forces IDLE next cycle, drops io_ack and io_dout_oe, and aborts with no RAM access. A write already issued completes.
- Opcodes:
  - 0x1 SET_ADDR: 4 further nibbles, most significant first, 16 bits assembled. ram_ada is loaded from bits [ADDR_W-1:0]; upper bits are ignored. err is cleared.
  - 0x2 WRITE: 2 further nibbles, high then low.
    - Ack of the low nibble is raised in the same cycle as ram_cea=ram_wrea=1 and ram_dina=byte.
    - The address increments the cycle after.
    - Further nibble pairs continue the burst until io_sel_n rises.
  - 0x3 READ:
    - On the opcode nibble, ram_cea=1, ram_wrea=0 for one cycle.
    - After RD_LATENCY cycles, ram_douta is latched into rd_buf and the address increments. Only then is io_ack raised for the opcode nibble.
    - Next strobe: io_dout=rd_buf[7:4], io_dout_oe=1. Following strobe: io_dout=rd_buf[3:0].
    - After the low nibble is acked, the next byte is pre-read the same way before the next ack. Bursting continues until io_sel_n rises.
  - Any other opcode: err=1, the nibble is acked, and the state machine enters DRAIN (acks all strobes, no RAM access) until io_sel_n rises.
- State machine states: IDLE, OPCODE, ADDR(n=0..3), WDATA_HI, WDATA_LO, RD_ISSUE, RD_WAIT, RD_HI, RD_LO, DRAIN.
  - A nibble counter tracks the ADDR sub-state.
  - An RD_LATENCY countdown drives RD_WAIT.
- Address arithmetic: 0x3FFF + 1 wraps to 0x0000, with no flag.
- Reset values: io_dout=0, io_dout_oe=0, io_ack=0, ram_ada=0, ram_dina=0, ram_cea=0, ram_wrea=0, busy=0, err=0, state=IDLE.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronous). Any RAM cycle in flight is dropped.

Decomposition:
- Shared package nibble_bus_pkg holds:
  - the opcode constants OP_SET_ADDR=4'h1, OP_WRITE=4'h2, OP_READ=4'h3;
  - the state enum;
  - ADDR_NIBBLES=4.
- One sub-module, nibble_bus_sync: a SYNC_STAGES-deep synchroniser plus rise/fall edge detector, instantiated for io_strobe and io_sel_n.

Test Plan:
- SET_ADDR 1,0,1,2,3: ram_ada=14'h0123, err=0, 5 acks, no ram_cea pulse.
- SET_ADDR 0x0100, then WRITE A,5 then 3,C: exactly two ram_cea&ram_wrea pulses, at addr 0x0100 data 0xA5 and addr 0x0101 data 0x3C; final ram_ada=0x0102.
- RAM model preloaded 0x0100=0xA5, 0x0101=0x3C; SET_ADDR 0x0100, READ, 4 strobes: io_dout sequence A,5,3,C with io_dout_oe=1; ram_cea read pulses at 0x0100, 0x0101, 0x0102 (pre-read).
- SET_ADDR 0x3FFF, WRITE 7,7 then 8,8: writes land at 0x3FFF then 0x0000; ram_ada=0x0001.
- Opcode 0x9 then 3 strobes: err=1, all 4 strobes acked, no ram_cea. Next frame SET_ADDR clears err.
- io_sel_n raised after WRITE high nibble only, then sys_rst_n pulsed low mid READ RD_WAIT: no write issued; state returns to IDLE; all outputs at reset values while reset is low.

Source files
------------

// File: rtl/nibble_bus_pkg.sv
// Shared constants and FSM state encoding for the Arduino nibble-bus RAM port.
package nibble_bus_pkg;

    localparam logic [3:0] OP_SET_ADDR  = 4'h1;
    localparam logic [3:0] OP_WRITE     = 4'h2;
    localparam logic [3:0] OP_READ      = 4'h3;
    localparam int         ADDR_NIBBLES = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_OPCODE,
        ST_ADDR,
        ST_WDATA_HI,
        ST_WDATA_LO,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RD_HI,
        ST_RD_LO,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/nibble_bus_ram_port_if.sv
// Arduino nibble bus plus RAM port-A signals; slave = the port controller.
interface nibble_bus_ram_port_if #(
    parameter int ADDR_W = 14
);
    logic              io_sel_n;
    logic              io_strobe;
    logic [3:0]        io_din;
    logic [3:0]        io_dout;
    logic              io_dout_oe;
    logic              io_ack;
    logic [ADDR_W-1:0] ram_ada;
    logic [7:0]        ram_dina;
    logic [7:0]        ram_douta;
    logic              ram_cea;
    logic              ram_wrea;
    logic              ram_ocea;
    logic              ram_reseta;

    modport slave (
        input  io_sel_n, io_strobe, io_din, ram_douta,
        output io_dout, io_dout_oe, io_ack,
        output ram_ada, ram_dina, ram_cea, ram_wrea, ram_ocea, ram_reseta
    );

    modport master (
        output io_sel_n, io_strobe, io_din, ram_douta,
        input  io_dout, io_dout_oe, io_ack,
        input  ram_ada, ram_dina, ram_cea, ram_wrea, ram_ocea, ram_reseta
    );
endinterface

// File: rtl/nibble_bus_sync.sv
// Multi-stage synchroniser for an asynchronous input with one-cycle rise/fall pulses.
module nibble_bus_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;
endmodule

// File: rtl/nibble_bus_ram_port.sv
// Decodes the Arduino four-phase nibble protocol (set address / write / read)
// into single-cycle accesses on RAM port A with an auto-incrementing pointer.
module nibble_bus_ram_port #(
    parameter int ADDR_W      = 14,
    parameter int SYNC_STAGES = 2,
    parameter int RD_LATENCY  = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    nibble_bus_ram_port_if.slave bus,
    output logic                 busy,
    output logic                 err
);
    import nibble_bus_pkg::*;

    localparam logic [3:0] LAT_INIT = 4'(RD_LATENCY - 1);

    logic stb_rise, stb_fall, stb_level_unused;
    logic sel_s, sel_fall, sel_rise_unused;
    logic stb_go;

    state_t            state_q, state_d;
    logic [1:0]        nib_cnt_q, nib_cnt_d;
    logic [3:0]        lat_q, lat_d;
    logic [11:0]       addr_sr_q, addr_sr_d;
    logic [3:0]        wr_hi_q, wr_hi_d;
    logic [7:0]        rd_buf_q, rd_buf_d;
    logic [ADDR_W-1:0] ada_q, ada_d;
    logic [7:0]        dina_q, dina_d;
    logic              cea_q, cea_d, wrea_q, wrea_d;
    logic              ack_q, ack_d, oe_q, oe_d, err_q, err_d;
    logic [3:0]        dout_q, dout_d;

    nibble_bus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_stb (
        .clk(sys_clk), .rst_n(sys_rst_n), .d(bus.io_strobe),
        .q(stb_level_unused), .rise(stb_rise), .fall(stb_fall)
    );

    nibble_bus_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sel (
        .clk(sys_clk), .rst_n(sys_rst_n), .d(bus.io_sel_n),
        .q(sel_s), .rise(sel_rise_unused), .fall(sel_fall)
    );

    // A rising strobe while the previous ack is still up violates the handshake; drop it.
    assign stb_go = stb_rise & ~ack_q;

    always_comb begin
        state_d   = state_q;
        nib_cnt_d = nib_cnt_q;
        lat_d     = lat_q;
        addr_sr_d = addr_sr_q;
        wr_hi_d   = wr_hi_q;
        rd_buf_d  = rd_buf_q;
        ada_d     = ada_q;
        dina_d    = dina_q;
        cea_d     = 1'b0;
        wrea_d    = 1'b0;
        ack_d     = ack_q;
        oe_d      = oe_q;
        err_d     = err_q;
        dout_d    = dout_q;

        // Writes bump the pointer the cycle after the enable pulse, even if the frame aborts.
        if (cea_q && wrea_q) ada_d = ada_q + ADDR_W'(1);
        if (ack_q && stb_fall) ack_d = 1'b0;

        if (state_q != ST_IDLE && sel_s) begin
            state_d = ST_IDLE;
            ack_d   = 1'b0;
            oe_d    = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: if (sel_fall) state_d = ST_OPCODE;
                ST_OPCODE: if (stb_go) begin
                    unique case (bus.io_din)
                        OP_SET_ADDR: begin nib_cnt_d = '0; ack_d = 1'b1; state_d = ST_ADDR; end
                        OP_WRITE:    begin ack_d = 1'b1; state_d = ST_WDATA_HI; end
                        OP_READ:     begin cea_d = 1'b1; state_d = ST_RD_ISSUE; end
                        default:     begin err_d = 1'b1; ack_d = 1'b1; state_d = ST_DRAIN; end
                    endcase
                end
                ST_ADDR: if (stb_go) begin
                    addr_sr_d = {addr_sr_q[7:0], bus.io_din};
                    ack_d     = 1'b1;
                    if (nib_cnt_q == 2'(ADDR_NIBBLES - 1)) begin
                        ada_d   = ADDR_W'({addr_sr_q, bus.io_din});
                        err_d   = 1'b0;
                        state_d = ST_OPCODE;
                    end else begin
                        nib_cnt_d = nib_cnt_q + 2'd1;
                    end
                end
                ST_WDATA_HI: if (stb_go) begin
                    wr_hi_d = bus.io_din;
                    ack_d   = 1'b1;
                    state_d = ST_WDATA_LO;
                end
                ST_WDATA_LO: if (stb_go) begin
                    dina_d  = {wr_hi_q, bus.io_din};
                    cea_d   = 1'b1;
                    wrea_d  = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ST_WDATA_HI;
                end
                ST_RD_ISSUE: begin
                    lat_d   = LAT_INIT;
                    state_d = ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (lat_q == '0) begin
                        rd_buf_d = bus.ram_douta;
                        ada_d    = ada_q + ADDR_W'(1);
                        // oe low means this is the opcode's read, whose ack is still owed.
                        if (!oe_q) ack_d = 1'b1;
                        state_d = ST_RD_HI;
                    end else begin
                        lat_d = lat_q - 4'd1;
                    end
                end
                ST_RD_HI: if (stb_go) begin
                    dout_d  = rd_buf_q[7:4];
                    oe_d    = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ST_RD_LO;
                end
                ST_RD_LO: if (stb_go) begin
                    dout_d  = rd_buf_q[3:0];
                    ack_d   = 1'b1;
                    cea_d   = 1'b1;
                    state_d = ST_RD_ISSUE;
                end
                ST_DRAIN: if (stb_go) ack_d = 1'b1;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            nib_cnt_q <= '0;
            lat_q     <= '0;
            addr_sr_q <= '0;
            wr_hi_q   <= '0;
            rd_buf_q  <= '0;
            ada_q     <= '0;
            dina_q    <= '0;
            cea_q     <= 1'b0;
            wrea_q    <= 1'b0;
            ack_q     <= 1'b0;
            oe_q      <= 1'b0;
            err_q     <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            nib_cnt_q <= nib_cnt_d;
            lat_q     <= lat_d;
            addr_sr_q <= addr_sr_d;
            wr_hi_q   <= wr_hi_d;
            rd_buf_q  <= rd_buf_d;
            ada_q     <= ada_d;
            dina_q    <= dina_d;
            cea_q     <= cea_d;
            wrea_q    <= wrea_d;
            ack_q     <= ack_d;
            oe_q      <= oe_d;
            err_q     <= err_d;
            dout_q    <= dout_d;
        end
    end

    assign bus.io_dout    = dout_q;
    assign bus.io_dout_oe = oe_q;
    assign bus.io_ack     = ack_q;
    assign bus.ram_ada    = ada_q;
    assign bus.ram_dina   = dina_q;
    assign bus.ram_cea    = cea_q;
    assign bus.ram_wrea   = wrea_q;
    assign bus.ram_ocea   = 1'b1;
    assign bus.ram_reseta = 1'b0;
    assign busy           = (state_q != ST_IDLE);
    assign err            = err_q;
endmodule

// File: tb/tb_nibble_bus_ram_port.sv
// Plays the Arduino side of the nibble bus against a behavioural RAM and a
// transaction-level model of pointer, error flag and memory contents.
module tb_nibble_bus_ram_port;
    localparam int ADDR_W = 14;
    localparam int DEPTH  = 1 << ADDR_W;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    logic busy, err;

    nibble_bus_ram_port_if #(.ADDR_W(ADDR_W)) bus ();

    nibble_bus_ram_port #(.ADDR_W(ADDR_W), .SYNC_STAGES(2), .RD_LATENCY(1)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus.slave), .busy(busy), .err(err)
    );

    always #5 sys_clk = ~sys_clk;

    // Behavioural RAM (bypass read: data valid the cycle after the enable) and access log.
    logic [7:0]        mem [DEPTH];
    logic [22:0]       wr_q [$];
    logic [ADDR_W-1:0] rd_q [$];

    always @(posedge sys_clk) begin
        if (bus.ram_cea) begin
            if (bus.ram_wrea) begin
                mem[bus.ram_ada] = bus.ram_dina;
                wr_q.push_back({bus.io_ack, bus.ram_ada, bus.ram_dina});
            end else begin
                bus.ram_douta <= mem[bus.ram_ada];
                rd_q.push_back(bus.ram_ada);
            end
        end
    end

    // Reference model
    logic [7:0]        ref_mem [DEPTH];
    logic [ADDR_W-1:0] model_addr;
    logic              model_err;
    logic [ADDR_W-1:0] rdbuf_addr;
    logic [22:0]       exp_wr [$];
    logic [ADDR_W-1:0] exp_rd [$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [3:0] d, output logic [3:0] rd, output logic rd_oe);
        logic seen;
        bus.io_din    = d;
        bus.io_strobe = 1'b1;
        seen  = 1'b0;
        rd    = '0;
        rd_oe = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge sys_clk);
            if (bus.io_ack) begin
                seen  = 1'b1;
                rd    = bus.io_dout;
                rd_oe = bus.io_dout_oe;
            end
        end
        check("ack_rise", 32'(seen), 32'(1));
        bus.io_strobe = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge sys_clk);
            if (!bus.io_ack) seen = 1'b1;
        end
        check("ack_fall", 32'(seen), 32'(1));
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic nib(input logic [3:0] d);
        logic [3:0] r;
        logic       o;
        xfer(d, r, o);
    endtask

    task automatic frame_begin();
        bus.io_sel_n = 1'b0;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic cmd_set_addr(input logic [15:0] a);
        nib(4'h1);
        nib(a[15:12]); nib(a[11:8]); nib(a[7:4]); nib(a[3:0]);
        model_addr = a[ADDR_W-1:0];
        model_err  = 1'b0;
        $display("[TB] SET_ADDR %04h", a);
    endtask

    task automatic wr_byte(input logic [7:0] b);
        nib(b[7:4]);
        nib(b[3:0]);
        exp_wr.push_back({1'b1, model_addr, b});
        ref_mem[model_addr] = b;
        $display("[TB] WR addr=%04h data=%02h", model_addr, b);
        model_addr = model_addr + ADDR_W'(1);
    endtask

    task automatic rd_open();
        nib(4'h3);
        exp_rd.push_back(model_addr);
        rdbuf_addr = model_addr;
        model_addr = model_addr + ADDR_W'(1);
    endtask

    task automatic rd_byte();
        logic [7:0] d;
        logic [3:0] nh, nl;
        logic       oh, ol;
        d = ref_mem[rdbuf_addr];
        xfer(4'h0, nh, oh);
        xfer(4'h0, nl, ol);
        check("rd_hi", 32'(nh), 32'(d[7:4]));
        check("rd_hi_oe", 32'(oh), 32'(1));
        check("rd_lo", 32'(nl), 32'(d[3:0]));
        check("rd_lo_oe", 32'(ol), 32'(1));
        $display("[TB] RD addr=%04h data=%02h", rdbuf_addr, {nh, nl});
        exp_rd.push_back(model_addr);
        rdbuf_addr = model_addr;
        model_addr = model_addr + ADDR_W'(1);
    endtask

    task automatic cmd_bad(input logic [3:0] op, input int extra);
        nib(op);
        for (int i = 0; i < extra; i++) nib(4'($urandom_range(0, 15)));
        model_err = 1'b1;
        $display("[TB] BAD opcode %0h + %0d strobes", op, extra);
    endtask

    task automatic frame_end(input string tag);
        bus.io_sel_n = 1'b1;
        repeat (6) @(negedge sys_clk);
        check({tag, "_wr_count"}, 32'(wr_q.size()), 32'(exp_wr.size()));
        while (wr_q.size() > 0 && exp_wr.size() > 0)
            check({tag, "_wr"}, 32'(wr_q.pop_front()), 32'(exp_wr.pop_front()));
        check({tag, "_rd_count"}, 32'(rd_q.size()), 32'(exp_rd.size()));
        while (rd_q.size() > 0 && exp_rd.size() > 0)
            check({tag, "_rd_addr"}, 32'(rd_q.pop_front()), 32'(exp_rd.pop_front()));
        check({tag, "_ada"}, 32'(bus.ram_ada), 32'(model_addr));
        check({tag, "_err"}, 32'(err), 32'(model_err));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_ack"}, 32'(bus.io_ack), 32'(0));
        check({tag, "_oe"}, 32'(bus.io_dout_oe), 32'(0));
        wr_q.delete(); exp_wr.delete(); rd_q.delete(); exp_rd.delete();
        $display("[TB] frame %s done addr=%04h err=%0d", tag, model_addr, model_err);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout"}, 32'(bus.io_dout), 32'(0));
        check({tag, "_oe"}, 32'(bus.io_dout_oe), 32'(0));
        check({tag, "_ack"}, 32'(bus.io_ack), 32'(0));
        check({tag, "_ada"}, 32'(bus.ram_ada), 32'(0));
        check({tag, "_dina"}, 32'(bus.ram_dina), 32'(0));
        check({tag, "_cea"}, 32'(bus.ram_cea), 32'(0));
        check({tag, "_wrea"}, 32'(bus.ram_wrea), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_err"}, 32'(err), 32'(0));
        check({tag, "_ocea"}, 32'(bus.ram_ocea), 32'(1));
        check({tag, "_reseta"}, 32'(bus.ram_reseta), 32'(0));
    endtask

    initial begin
        logic seen;
        int   kind;
        logic [3:0] op;

        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        model_addr    = '0;
        model_err     = 1'b0;
        rdbuf_addr    = '0;
        bus.io_sel_n  = 1'b1;
        bus.io_strobe = 1'b0;
        bus.io_din    = 4'h0;

        repeat (3) @(negedge sys_clk);
        check_reset_outputs("reset");
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);

        // SET_ADDR 0x0123
        frame_begin();
        cmd_set_addr(16'h0123);
        frame_end("setaddr");

        // Two-byte write burst at 0x0100
        frame_begin();
        cmd_set_addr(16'h0100);
        nib(4'h2);
        wr_byte(8'hA5);
        wr_byte(8'h3C);
        frame_end("write");

        // Read burst with explicit preload
        mem[14'h0100] = 8'hA5; ref_mem[14'h0100] = 8'hA5;
        mem[14'h0101] = 8'h3C; ref_mem[14'h0101] = 8'h3C;
        frame_begin();
        cmd_set_addr(16'h0100);
        rd_open();
        rd_byte();
        rd_byte();
        frame_end("read");

        // Pointer wrap
        frame_begin();
        cmd_set_addr(16'h3FFF);
        nib(4'h2);
        wr_byte(8'h77);
        wr_byte(8'h88);
        frame_end("wrap");

        // Unknown opcode drains, then SET_ADDR clears err
        frame_begin();
        cmd_bad(4'h9, 3);
        frame_end("badop");
        frame_begin();
        cmd_set_addr(16'h0040);
        frame_end("errclr");

        // Abort after the high write nibble: nothing may reach the RAM
        frame_begin();
        nib(4'h2);
        nib(4'hA);
        frame_end("abort");

        // Asynchronous reset while the read waits on RAM latency
        frame_begin();
        bus.io_din    = 4'h3;
        bus.io_strobe = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge sys_clk);
            if (bus.ram_cea) seen = 1'b1;
        end
        check("rst_rd_issue", 32'(seen), 32'(1));
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        bus.io_strobe = 1'b0;
        bus.io_sel_n  = 1'b1;
        repeat (3) @(negedge sys_clk);
        check_reset_outputs("midrst_hold");
        sys_rst_n = 1'b1;
        repeat (4) @(negedge sys_clk);
        model_addr = '0;
        model_err  = 1'b0;
        wr_q.delete(); rd_q.delete(); exp_wr.delete(); exp_rd.delete();
        check("postrst_busy", 32'(busy), 32'(0));
        check("postrst_cea_log", 32'(wr_q.size() + rd_q.size()), 32'(0));

        // Randomised frames
        for (int f = 0; f < 30; f++) begin
            frame_begin();
            if ($urandom_range(0, 2) != 0) begin
                if ($urandom_range(0, 3) == 0)
                    cmd_set_addr(16'hFFFE - 16'($urandom_range(0, 3)));
                else
                    cmd_set_addr(16'($urandom));
            end
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin
                    nib(4'h2);
                    for (int b = 0; b < $urandom_range(1, 4); b++) wr_byte(8'($urandom));
                end
                1: begin
                    rd_open();
                    for (int b = 0; b < $urandom_range(1, 3); b++) rd_byte();
                end
                2: begin
                    op = 4'($urandom_range(0, 12));
                    if (op != 4'h0) op = op + 4'd3;
                    cmd_bad(op, $urandom_range(0, 2));
                end
                default: ;
            endcase
            frame_end("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
